// File: rtl/seq_trace_readback.sv
// Trace buffer for the sequencer's config words: captures one 64-word run after
// the falling edge of seq_en, then streams it back high byte first over valid/ready.
module seq_trace_readback #(
    parameter int ADDR_W = 6,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seq_en,
    input  logic [WORD_W-1:0] cfg_in,
    input  logic              cap_arm,
    input  logic              rd_req,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              busy,
    output logic              full,
    output logic              done,
    output logic [ADDR_W:0]   word_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_FULL,
        S_READ
    } state_t;

    state_t state_reg, state_next;

    logic              seq_en_reg;
    logic [WORD_W-1:0] trace_mem [DEPTH];
    logic [WORD_W-1:0] rd_data_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic [7:0]        lo_reg;
    logic [ADDR_W:0]   byte_idx_reg;

    logic seq_fall;
    logic handshake;
    logic last_byte;
    logic cap_we;
    logic cnt_clr;
    logic load_first;

    assign seq_fall  = seq_en_reg & ~seq_en;
    assign handshake = byte_valid & byte_ready;
    assign last_byte = handshake & (&byte_idx_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cap_we     = 1'b0;
        cnt_clr    = 1'b0;
        load_first = 1'b0;
        busy       = 1'b0;
        full       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (cap_arm) begin
                    state_next = S_ARMED;
                    cnt_clr    = 1'b1;
                end
            end
            S_ARMED: begin
                busy = 1'b1;
                // The falling-edge cycle itself supplies word 0.
                if (seq_fall) begin
                    cap_we     = 1'b1;
                    state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                busy   = 1'b1;
                cap_we = 1'b1;
                if (&word_cnt[ADDR_W-1:0]) begin
                    state_next = S_FULL;
                end
            end
            S_FULL: begin
                full = 1'b1;
                if (rd_req) begin
                    state_next = S_READ;
                end else if (cap_arm) begin
                    state_next = S_ARMED;
                    cnt_clr    = 1'b1;
                end
            end
            S_READ: begin
                busy       = 1'b1;
                load_first = ~byte_valid;
                if (last_byte) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Address is parked at 0 outside READ so word 0 is already on rd_data_reg
    // when readback starts; later words are fetched one byte ahead of use.
    always_ff @(posedge clk) begin
        if (cap_we) begin
            trace_mem[word_cnt[ADDR_W-1:0]] <= cfg_in;
        end
        rd_data_reg <= trace_mem[rd_addr_reg];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_en_reg   <= 1'b0;
            word_cnt     <= '0;
            byte_out     <= '0;
            byte_valid   <= 1'b0;
            done         <= 1'b0;
            rd_addr_reg  <= '0;
            lo_reg       <= '0;
            byte_idx_reg <= '0;
        end else begin
            seq_en_reg <= seq_en;
            done       <= 1'b0;

            if (cnt_clr) begin
                word_cnt <= '0;
            end else if (cap_we) begin
                word_cnt <= word_cnt + 1'b1;
            end

            if (state_reg != S_READ) begin
                rd_addr_reg <= '0;
            end else if (load_first) begin
                byte_out     <= rd_data_reg[WORD_W-1:8];
                lo_reg       <= rd_data_reg[7:0];
                byte_valid   <= 1'b1;
                byte_idx_reg <= '0;
                rd_addr_reg  <= rd_addr_reg + 1'b1;
            end else if (handshake) begin
                byte_idx_reg <= byte_idx_reg + 1'b1;
                if (last_byte) begin
                    byte_valid <= 1'b0;
                    done       <= 1'b1;
                end else if (!byte_idx_reg[0]) begin
                    byte_out <= lo_reg;
                end else begin
                    byte_out    <= rd_data_reg[WORD_W-1:8];
                    lo_reg      <= rd_data_reg[7:0];
                    rd_addr_reg <= rd_addr_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_trace_readback.sv
// Bench for seq_trace_readback: random captures recorded into a reference array,
// expected readback bytes queued and checked by an independent monitor.
module tb_seq_trace_readback;

    logic        clk = 1'b0;
    logic        rst;
    logic        seq_en;
    logic [15:0] cfg_in;
    logic        cap_arm;
    logic        rd_req;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        busy;
    logic        full;
    logic        done;
    logic [6:0]  word_cnt;

    int checks = 0;
    int errs   = 0;

    logic [15:0] ref_buf [64];
    logic [7:0]  exp_q [$];
    int          hs_total = 0;
    int          hs_base  = 0;
    int          ready_mode = 0;

    seq_trace_readback #(.ADDR_W(6), .WORD_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .seq_en     (seq_en),
        .cfg_in     (cfg_in),
        .cap_arm    (cap_arm),
        .rd_req     (rd_req),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .full       (full),
        .done       (done),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    // Host side: 0 = always ready, 1 = random, 2 = hold off 5 clk on byte 3.
    initial begin
        int stall_cnt;
        stall_cnt  = 0;
        byte_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: byte_ready = 1'b1;
                1: byte_ready = 1'($urandom);
                default: begin
                    if (hs_total - hs_base < 3) stall_cnt = 0;
                    if (hs_total - hs_base == 3 && stall_cnt < 5 && byte_valid) begin
                        byte_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        byte_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: compares every accepted byte against the scoreboard queue.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_byte;
        logic [7:0] e;
        prev_stall = 1'b0;
        prev_byte  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                checks++;
                if (!byte_valid || byte_out !== prev_byte) begin
                    errs++;
                    $display("FAIL stall_hold: valid=%0b byte=%02h, required valid=1 byte=%02h",
                             byte_valid, byte_out, prev_byte);
                end
            end
            if (byte_valid && byte_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_byte: got %02h with nothing expected", byte_out);
                end else begin
                    e = exp_q.pop_front();
                    $display("byte %0d got=%02h exp=%02h", hs_total - hs_base, byte_out, e);
                    if (byte_out !== e) begin
                        errs++;
                        $display("FAIL byte_data: got %02h required %02h", byte_out, e);
                    end
                end
                hs_total++;
            end
            prev_stall = byte_valid && !byte_ready;
            prev_byte  = byte_out;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Arm, hold seq_en low then high, then drop it with word 0 and feed 63 more words.
    task automatic do_capture(input int pre_low, input int high_len, input bit ramp,
                              input bit toggle, input bit rd_during);
        seq_en  = 1'b0;
        cap_arm = 1'b1;
        tick();
        cap_arm = 1'b0;
        repeat (pre_low) tick();
        chk("armed_busy", 32'(busy), 1);
        chk("armed_no_capture_cnt", 32'(word_cnt), 0);
        chk("armed_not_full", 32'(full), 0);
        seq_en = 1'b1;
        repeat (high_len) tick();
        chk("armed_high_no_capture", 32'(word_cnt), 0);
        for (int n = 0; n < 64; n++) begin
            ref_buf[n] = ramp ? 16'(16'h1000 + n) : 16'($urandom);
            cfg_in     = ref_buf[n];
            seq_en     = (n == 0) ? 1'b0 : (toggle ? 1'($urandom) : 1'b0);
            rd_req     = rd_during && (n == 20);
            tick();
            if (n == 31) chk("cnt_mid_capture", 32'(word_cnt), 32);
            if (n == 62) chk("not_full_after_63", 32'(full), 0);
        end
        seq_en = 1'b0;
        rd_req = 1'b0;
        chk("full_after_64", 32'(full), 1);
        chk("word_cnt_64", 32'(word_cnt), 64);
        chk("busy_low_in_full", 32'(busy), 0);
        chk("no_valid_in_full", 32'(byte_valid), 0);
    endtask

    task automatic push_expected;
        for (int k = 0; k < 64; k++) begin
            exp_q.push_back(ref_buf[k][15:8]);
            exp_q.push_back(ref_buf[k][7:0]);
        end
    endtask

    task automatic do_read(input int mode, input bit with_arm);
        int cyc;
        bit got_done;
        push_expected();
        hs_base    = hs_total;
        ready_mode = mode;
        rd_req     = 1'b1;
        cap_arm    = with_arm;
        tick();
        rd_req  = 1'b0;
        cap_arm = 1'b0;
        got_done = 1'b0;
        cyc      = 0;
        while (!got_done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            got_done = done;
        end
        chk("done_seen", 32'(got_done), 1);
        if (got_done) begin
            chk("valid_low_at_done", 32'(byte_valid), 0);
            chk("busy_low_at_done", 32'(busy), 0);
            chk("bytes_remaining", 32'(exp_q.size()), 0);
            chk("bytes_accepted", 32'(hs_total - hs_base), 128);
            if (mode == 0) chk("full_rate_cycles_le_131", 32'(cyc <= 131), 1);
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 0);
        end
        exp_q.delete();
        tick();
    endtask

    task automatic expect_no_valid(input string name, input int cycles);
        bit seen;
        seen = 1'b0;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (byte_valid) seen = 1'b1;
        end
        chk(name, 32'(seen), 0);
        tick();
    endtask

    initial begin
        rst     = 1'b1;
        seq_en  = 1'b0;
        cfg_in  = '0;
        cap_arm = 1'b0;
        rd_req  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_byte_valid", 32'(byte_valid), 0);
        chk("rst_byte_out", 32'(byte_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_word_cnt", 32'(word_cnt), 0);
        rst = 1'b0;
        tick();

        // Ramp capture and full-rate readback.
        do_capture(2, 3, 1'b1, 1'b0, 1'b0);
        do_read(0, 1'b0);
        chk("word_cnt_holds_after_read", 32'(word_cnt), 64);
        expect_no_valid("rd_req_ignored_in_idle", 8);

        // seq_en low at arm, toggling and rd_req during capture; arm+rd together, backpressure.
        do_capture(10, 2, 1'b0, 1'b1, 1'b1);
        do_read(2, 1'b1);
        chk("word_cnt_after_arm_rd", 32'(word_cnt), 64);

        // cap_arm alone in FULL discards the trace.
        do_capture(3, 4, 1'b0, 1'b0, 1'b0);
        cap_arm = 1'b1;
        tick();
        cap_arm = 1'b0;
        chk("rearm_busy", 32'(busy), 1);
        chk("rearm_full_clear", 32'(full), 0);
        chk("rearm_word_cnt", 32'(word_cnt), 0);
        do_capture(1, 1, 1'b0, 1'b1, 1'b0);
        do_read(1, 1'b0);

        // Reset in the middle of a readback.
        do_capture(2, 2, 1'b0, 1'b0, 1'b0);
        push_expected();
        hs_base    = hs_total;
        ready_mode = 1;
        rd_req     = 1'b1;
        tick();
        rd_req = 1'b0;
        repeat (40) @(negedge clk);
        chk("read_in_progress", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("midrd_rst_byte_valid", 32'(byte_valid), 0);
        chk("midrd_rst_busy", 32'(busy), 0);
        chk("midrd_rst_full", 32'(full), 0);
        chk("midrd_rst_done", 32'(done), 0);
        chk("midrd_rst_word_cnt", 32'(word_cnt), 0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        expect_no_valid("rd_req_after_rst_ignored", 10);
        chk("idle_after_rst_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule
